// File: rtl/gm_sram_slave_if.sv
// GM master-port bus between the encoder AXI bridge and its responder.
interface gm_sram_slave_if #(
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_AW = 32
);
  logic [AXI_AW-1:0]   gm_maddr;
  logic [1:0]          gm_mburst;
  logic [3:0]          gm_mcache;
  logic                gm_mlock;
  logic [2:0]          gm_mprot;
  logic [AXI_DW-1:0]   gm_mdata;
  logic [AXI_DW/8-1:0] gm_mwstrb;
  logic [3:0]          gm_mid;
  logic [3:0]          gm_mlen;
  logic [2:0]          gm_msize;
  logic                gm_mread;
  logic                gm_mwrite;
  logic                gm_mready;
  logic                gm_saccept;
  logic [AXI_DW-1:0]   gm_sdata;
  logic [3:0]          gm_sid;
  logic                gm_slast;
  logic [2:0]          gm_sresp;
  logic                gm_svalid;

  modport master (
    output gm_maddr, gm_mburst, gm_mcache, gm_mlock, gm_mprot, gm_mdata, gm_mwstrb,
           gm_mid, gm_mlen, gm_msize, gm_mread, gm_mwrite, gm_mready,
    input  gm_saccept, gm_sdata, gm_sid, gm_slast, gm_sresp, gm_svalid
  );

  modport slave (
    input  gm_maddr, gm_mburst, gm_mcache, gm_mlock, gm_mprot, gm_mdata, gm_mwstrb,
           gm_mid, gm_mlen, gm_msize, gm_mread, gm_mwrite, gm_mready,
    output gm_saccept, gm_sdata, gm_sid, gm_slast, gm_sresp, gm_svalid
  );
endinterface

// File: rtl/gm_sram_slave.sv
// GM burst responder backed by an on-chip 64-bit SRAM; reads drain through a
// 2-entry output skid buffer whose head entry drives the response port.
module gm_sram_slave #(
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned MEM_AW = 12
) (
  input  logic           axi_clk,
  input  logic           axi_rst,
  gm_sram_slave_if.slave gm
);
  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned SW    = AXI_DW / 8;
  localparam int unsigned LW    = 4;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW:0]         beat_q, beat_d;
  logic                fixed_q, fixed_d;
  logic [3:0]          id_q, id_d;
  logic                err_q, err_d;
  logic                accept_q, accept_d;
  logic                v0_q, v0_d, v1_q, v1_d;
  logic                last0_q, last0_d, last1_q, last1_d;
  logic [AXI_DW-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                infl_q, infl_d, infl_last_q, infl_last_d;
  logic [AXI_DW-1:0]   rd_data_q;
  logic [AXI_DW-1:0]   mem [DEPTH];

  logic                mem_we_c, mem_re_c, pop_c, issue_ok_c;
  logic [MEM_AW-1:0]   mem_addr_c, cmd_word_c, cmd_next_c, addr_next_c;
  logic [1:0]          occ_c;
  logic [AXI_DW-1:0]   push_data_c;
  logic                unused_c;

  assign cmd_word_c  = gm.gm_maddr[MEM_AW+2:3];
  assign cmd_next_c  = (gm.gm_mburst == 2'b00) ? cmd_word_c : cmd_word_c + MEM_AW'(1);
  assign addr_next_c = fixed_q ? addr_q : addr_q + MEM_AW'(1);
  assign push_data_c = err_q ? '0 : rd_data_q;
  assign unused_c    = ^{gm.gm_mcache, gm.gm_mlock, gm.gm_mprot,
                         gm.gm_maddr[AXI_AW-1:MEM_AW+3], gm.gm_maddr[2:0]};

  // Next-state, skid-buffer and SRAM-port control
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    fixed_d     = fixed_q;
    id_d        = id_q;
    err_d       = err_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = addr_q;

    pop_c      = v0_q & gm.gm_mready;
    // Slots held after this cycle, counting the read already in the SRAM pipe
    occ_c      = 2'(v0_q) + 2'(v1_q) + 2'(infl_q) - 2'(pop_c);
    issue_ok_c = (occ_c < 2'd2);

    if (pop_c) begin
      v0_d    = v1_q;
      data0_d = data1_q;
      last0_d = last1_q;
      v1_d    = 1'b0;
    end
    if (infl_q) begin
      if (!v0_d) begin
        v0_d    = 1'b1;
        data0_d = push_data_c;
        last0_d = infl_last_q;
      end else begin
        v1_d    = 1'b1;
        data1_d = push_data_c;
        last1_d = infl_last_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept_q && (gm.gm_mwrite || gm.gm_mread)) begin
          fixed_d    = (gm.gm_mburst == 2'b00);
          len_d      = gm.gm_mlen;
          id_d       = gm.gm_mid;
          err_d      = (gm.gm_msize != 3'd3);
          addr_d     = cmd_next_c;
          beat_d     = (LW+1)'(1);
          mem_addr_c = cmd_word_c;
          if (gm.gm_mwrite) begin
            mem_we_c = (gm.gm_msize == 3'd3);
            if (gm.gm_mlen == '0) begin
              state_d = WR_RESP;
              v0_d    = 1'b1;
              last0_d = 1'b1;
              data0_d = '0;
            end else begin
              state_d = WR_DATA;
            end
          end else begin
            mem_re_c    = 1'b1;
            infl_d      = 1'b1;
            infl_last_d = (gm.gm_mlen == '0);
            state_d     = RD_DATA;
          end
        end
      end
      WR_DATA: begin
        if (gm.gm_mwrite) begin
          mem_we_c = !err_q;
          addr_d   = addr_next_c;
          beat_d   = beat_q + (LW+1)'(1);
          if (beat_q[LW-1:0] == len_q) begin
            state_d = WR_RESP;
            v0_d    = 1'b1;
            last0_d = 1'b1;
            data0_d = '0;
          end
        end
      end
      WR_RESP: begin
        if (pop_c) state_d = IDLE;
      end
      RD_DATA: begin
        if ((beat_q <= {1'b0, len_q}) && issue_ok_c) begin
          mem_re_c    = 1'b1;
          infl_d      = 1'b1;
          infl_last_d = (beat_q[LW-1:0] == len_q);
          addr_d      = addr_next_c;
          beat_d      = beat_q + (LW+1)'(1);
        end
        if (pop_c && last0_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept_d = (state_d == IDLE) || (state_d == WR_DATA);
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      fixed_q     <= 1'b0;
      id_q        <= '0;
      err_q       <= 1'b0;
      accept_q    <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      fixed_q     <= fixed_d;
      id_q        <= id_d;
      err_q       <= err_d;
      accept_q    <= accept_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Single-port SRAM with byte enables and registered read data
  always_ff @(posedge axi_clk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (gm.gm_mwstrb[b]) mem[mem_addr_c][b*8 +: 8] <= gm.gm_mdata[b*8 +: 8];
      end
    end
    if (mem_re_c) rd_data_q <= mem[mem_addr_c];
  end

  assign gm.gm_saccept = accept_q;
  assign gm.gm_svalid  = v0_q;
  assign gm.gm_sdata   = data0_q;
  assign gm.gm_slast   = last0_q;
  assign gm.gm_sid     = id_q;
  assign gm.gm_sresp   = {1'b0, err_q, 1'b0};
endmodule

// File: tb/tb_gm_sram_slave.sv
// Directed bench for gm_sram_slave: table of write/read bursts plus
// hand-written backpressure, priority and mid-burst reset sequences.
module tb_gm_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gm_sram_slave_if #(.AXI_DW(64), .AXI_AW(32)) gm_if ();

  gm_sram_slave #(.AXI_DW(64), .AXI_AW(32), .MEM_AW(12)) dut (
    .axi_clk (clk),
    .axi_rst (rst),
    .gm      (gm_if)
  );

  typedef struct {
    bit              wr;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [1:0]      burst;
    logic [3:0]      id;
    logic [2:0]      size;
    logic [7:0]      strb;
    logic [3:0][63:0] data;   // write data, or expected read data
    logic [2:0]      resp;
  } vec_t;

  function automatic vec_t mkv(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [3:0] id, input logic [2:0] size,
                               input logic [7:0] strb, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3, input logic [2:0] resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.id = id;
    v.size = size; v.strb = strb; v.resp = resp;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gm_if.gm_maddr  = '0; gm_if.gm_mburst = 2'b01; gm_if.gm_mcache = '0;
    gm_if.gm_mlock  = 1'b0; gm_if.gm_mprot = '0; gm_if.gm_mdata = '0;
    gm_if.gm_mwstrb = '0; gm_if.gm_mid = '0; gm_if.gm_mlen = '0;
    gm_if.gm_msize  = 3'd3; gm_if.gm_mread = 1'b0; gm_if.gm_mwrite = 1'b0;
    gm_if.gm_mready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] id, input logic [2:0] size,
                          input logic [7:0] strb, input logic [15:0][63:0] d, input logic [2:0] resp);
    chk({tag, ".accept"}, 64'(gm_if.gm_saccept), 64'd1);
    gm_if.gm_maddr = addr; gm_if.gm_mlen = len; gm_if.gm_mburst = burst;
    gm_if.gm_mid = id; gm_if.gm_msize = size; gm_if.gm_mwstrb = strb;
    gm_if.gm_mwrite = 1'b1; gm_if.gm_mdata = d[0];
    step();
    for (int i = 1; i <= int'(len); i++) begin
      gm_if.gm_mdata = d[i];
      step();
    end
    gm_if.gm_mwrite = 1'b0;
    chk({tag, ".bvalid"}, 64'(gm_if.gm_svalid), 64'd1);
    chk({tag, ".blast"},  64'(gm_if.gm_slast),  64'd1);
    chk({tag, ".bresp"},  64'(gm_if.gm_sresp),  64'(resp));
    chk({tag, ".bid"},    64'(gm_if.gm_sid),    64'(id));
    chk({tag, ".bdata"},  gm_if.gm_sdata,       64'd0);
    gm_if.gm_mready = 1'b1;
    step();
    gm_if.gm_mready = 1'b0;
    chk({tag, ".bdone"}, 64'(gm_if.gm_svalid), 64'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [3:0] id, input logic [2:0] size,
                         input logic [15:0][63:0] exp, input logic [2:0] resp, input bit bp);
    int          k = 0;
    int          cyc = 0;
    bit          stalled = 0;
    bit          rdy;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;
    chk({tag, ".accept"}, 64'(gm_if.gm_saccept), 64'd1);
    gm_if.gm_maddr = addr; gm_if.gm_mlen = len; gm_if.gm_mburst = burst;
    gm_if.gm_mid = id; gm_if.gm_msize = size; gm_if.gm_mread = 1'b1;
    gm_if.gm_mready = 1'b0;
    step();
    gm_if.gm_mread = 1'b0;
    chk({tag, ".lat1"}, 64'(gm_if.gm_svalid), 64'd0);
    step();
    while (k <= int'(len) && cyc < 200) begin
      rdy = bp ? ((cyc % 3) == 0) : 1'b1;
      gm_if.gm_mready = rdy;
      if (cyc == 0) chk({tag, ".lat2"}, 64'(gm_if.gm_svalid), 64'd1);
      if (stalled) begin
        chk({tag, ".hold_v"}, 64'(gm_if.gm_svalid), 64'd1);
        chk({tag, ".hold_d"}, gm_if.gm_sdata, held_data);
        chk({tag, ".hold_l"}, 64'(gm_if.gm_slast), 64'(held_last));
      end
      if (gm_if.gm_svalid && rdy) begin
        chk($sformatf("%s.data%0d", tag, k), gm_if.gm_sdata, exp[k]);
        chk($sformatf("%s.last%0d", tag, k), 64'(gm_if.gm_slast), 64'(k == int'(len)));
        chk($sformatf("%s.id%0d", tag, k), 64'(gm_if.gm_sid), 64'(id));
        chk($sformatf("%s.resp%0d", tag, k), 64'(gm_if.gm_sresp), 64'(resp));
        k++;
      end
      stalled   = gm_if.gm_svalid && !rdy;
      held_data = gm_if.gm_sdata;
      held_last = gm_if.gm_slast;
      step();
      cyc++;
    end
    gm_if.gm_mready = 1'b0;
    chk({tag, ".beats"}, 64'(k), 64'(int'(len) + 1));
    chk({tag, ".idle_acc"}, 64'(gm_if.gm_saccept), 64'd1);
    chk({tag, ".idle_v"}, 64'(gm_if.gm_svalid), 64'd0);
  endtask

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] DA = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] DB = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] F  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl [14];
    logic [15:0][63:0] d;

    tbl[0]  = mkv(1, 32'h0000_0100, 4'd3, 2'b01, 4'd5, 3'd3, 8'hFF, D1, D2, D3, D4, 3'b000);
    tbl[1]  = mkv(0, 32'h0000_0100, 4'd3, 2'b01, 4'd5, 3'd3, 8'hFF, D1, D2, D3, D4, 3'b000);
    tbl[2]  = mkv(1, 32'h0000_0000, 4'd0, 2'b01, 4'd1, 3'd3, 8'hFF, F, 0, 0, 0, 3'b000);
    tbl[3]  = mkv(1, 32'h0000_0000, 4'd0, 2'b01, 4'd2, 3'd3, 8'h0F, 0, 0, 0, 0, 3'b000);
    tbl[4]  = mkv(0, 32'h0000_0000, 4'd0, 2'b01, 4'd3, 3'd3, 8'h00,
                  64'hFFFF_FFFF_0000_0000, 0, 0, 0, 3'b000);
    tbl[5]  = mkv(1, 32'h0000_7FF8, 4'd1, 2'b01, 4'd6, 3'd3, 8'hFF, DA, DB, 0, 0, 3'b000);
    tbl[6]  = mkv(0, 32'h0000_7FF8, 4'd0, 2'b01, 4'd6, 3'd3, 8'h00, DA, 0, 0, 0, 3'b000);
    tbl[7]  = mkv(0, 32'h0000_0000, 4'd0, 2'b01, 4'd6, 3'd3, 8'h00, DB, 0, 0, 0, 3'b000);
    tbl[8]  = mkv(0, 32'h0000_8000, 4'd0, 2'b01, 4'd9, 3'd3, 8'h00, DB, 0, 0, 0, 3'b000);
    tbl[9]  = mkv(0, 32'h0000_0100, 4'd2, 2'b00, 4'd4, 3'd3, 8'h00, D1, D1, D1, 0, 3'b000);
    tbl[10] = mkv(1, 32'h0000_0100, 4'd0, 2'b01, 4'd8, 3'd2, 8'hFF,
                  64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 3'b010);
    tbl[11] = mkv(0, 32'h0000_0100, 4'd0, 2'b01, 4'd8, 3'd3, 8'h00, D1, 0, 0, 0, 3'b000);
    tbl[12] = mkv(0, 32'h0000_0100, 4'd1, 2'b01, 4'd2, 3'd2, 8'h00, 0, 0, 0, 0, 3'b010);
    tbl[13] = mkv(0, 32'h0000_0100, 4'd1, 2'b10, 4'd7, 3'd3, 8'h00, D1, D2, 0, 0, 3'b000);

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.accept", 64'(gm_if.gm_saccept), 64'd0);
    chk("rst.valid",  64'(gm_if.gm_svalid),  64'd0);
    chk("rst.last",   64'(gm_if.gm_slast),   64'd0);
    chk("rst.id",     64'(gm_if.gm_sid),     64'd0);
    chk("rst.resp",   64'(gm_if.gm_sresp),   64'd0);
    chk("rst.data",   gm_if.gm_sdata,        64'd0);
    rst = 1'b0;
    step();
    chk("rst.accept_rise", 64'(gm_if.gm_saccept), 64'd1);

    for (int i = 0; i < 14; i++) begin
      d = '0;
      for (int j = 0; j < 4; j++) d[j] = tbl[i].data[j];
      if (tbl[i].wr)
        do_write($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].id,
                 tbl[i].size, tbl[i].strb, d, tbl[i].resp);
      else
        do_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].id,
                tbl[i].size, d, tbl[i].resp, 1'b0);
    end

    // 8-beat read with mready pattern 1,0,0 repeating
    d = '0;
    for (int i = 0; i < 8; i++) d[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    do_write("bp.w", 32'h0000_0200, 4'd7, 2'b01, 4'd3, 3'd3, 8'hFF, d, 3'b000);
    do_read("bp.r", 32'h0000_0200, 4'd7, 2'b01, 4'd3, 3'd3, d, 3'b000, 1'b1);

    // Write wins when read and write are requested together
    chk("prio.accept", 64'(gm_if.gm_saccept), 64'd1);
    gm_if.gm_maddr = 32'h0000_1800; gm_if.gm_mlen = 4'd0; gm_if.gm_mburst = 2'b01;
    gm_if.gm_mid = 4'd7; gm_if.gm_msize = 3'd3; gm_if.gm_mwstrb = 8'hFF;
    gm_if.gm_mdata = 64'h0000_0000_00C0_FFEE;
    gm_if.gm_mwrite = 1'b1; gm_if.gm_mread = 1'b1;
    step();
    gm_if.gm_mwrite = 1'b0; gm_if.gm_mread = 1'b0;
    chk("prio.bvalid", 64'(gm_if.gm_svalid), 64'd1);
    chk("prio.blast",  64'(gm_if.gm_slast),  64'd1);
    chk("prio.bdata",  gm_if.gm_sdata,       64'd0);
    gm_if.gm_mready = 1'b1;
    step();
    gm_if.gm_mready = 1'b0;
    d = '0;
    d[0] = 64'h0000_0000_00C0_FFEE;
    do_read("prio.r", 32'h0000_1800, 4'd0, 2'b01, 4'd7, 3'd3, d, 3'b000, 1'b0);

    // Reset asserted while beat 2 of a 4-beat read is presented
    gm_if.gm_maddr = 32'h0000_0100; gm_if.gm_mlen = 4'd3; gm_if.gm_mburst = 2'b01;
    gm_if.gm_mid = 4'd5; gm_if.gm_msize = 3'd3; gm_if.gm_mread = 1'b1;
    step();
    gm_if.gm_mread = 1'b0;
    gm_if.gm_mready = 1'b1;
    step();
    chk("mrst.beat0", gm_if.gm_sdata, D1);
    step();
    chk("mrst.beat1", gm_if.gm_sdata, D2);
    step();
    chk("mrst.beat2", gm_if.gm_sdata, D3);
    rst = 1'b1;
    #1;
    chk("mrst.valid",  64'(gm_if.gm_svalid),  64'd0);
    chk("mrst.accept", 64'(gm_if.gm_saccept), 64'd0);
    chk("mrst.data",   gm_if.gm_sdata,        64'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("mrst.accept_rise", 64'(gm_if.gm_saccept), 64'd1);
    d = '0;
    d[0] = D2; d[1] = D3;
    do_read("mrst.r", 32'h0000_0108, 4'd1, 2'b01, 4'd1, 3'd3, d, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gm_sram_slave.md
# gm_sram_slave

Responder for the encoder's GM master port: accepts GM read/write bursts from `h264enc_axi_if` and serves them from an on-chip 64-bit-wide SRAM. It stands in for the DDR path in block-level and FPGA loopback benches, and holds source frames (pixel reads) and the bitstream/reconstruction buffers (writes).

## Interface
Parameters:
- `AXI_DW`, 64: data width; only 64 is supported.
- `AXI_AW`, 32: address width.
- `MEM_AW`, 12: log2 of the SRAM depth in 64-bit words.

Ports:
- `axi_clk`  in  1  single clock; all logic is on its rising edge.
- `axi_rst`  in  1  asynchronous, active-high reset.
- `gm_maddr`  in  AXI_AW  byte address of the first beat.
- `gm_mburst`  in  2  burst type: 00 FIXED, 01 INCR; other codes are treated as INCR.
- `gm_mcache`, `gm_mlock`, `gm_mprot`  in  4/1/3  ignored.
- `gm_mdata`  in  AXI_DW  write data.
- `gm_mwstrb`  in  AXI_DW/8  byte strobes.
- `gm_mid`  in  4  transaction ID.
- `gm_mlen`  in  4  beats minus 1.
- `gm_msize`  in  3  beat size; only 3 (8 bytes) is legal.
- `gm_mread`  in  1  read command request.
- `gm_mwrite`  in  1  write command/beat request.
- `gm_mready`  in  1  master accepts the response beat.
- `gm_saccept`  out  1  slave accepts the command or write beat.
- `gm_sdata`  out  AXI_DW  read data.
- `gm_sid`  out  4  ID of the response.
- `gm_slast`  out  1  last response beat.
- `gm_sresp`  out  3  response code: 000 OKAY, 010 SLVERR.
- `gm_svalid`  out  1  response beat valid.

## Operation
- Word index: `gm_maddr[MEM_AW+2:3]`. Upper address bits are ignored, so accesses alias modulo the SRAM size. `maddr[2:0]` is ignored.
- Beat address: FIXED keeps the same word for every beat. INCR adds 1 per beat and wraps modulo 2^MEM_AW.
- Latched at command accept: `maddr`, `mlen`, `mburst`, `mid`, and error = (`msize` != 3).
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - `gm_saccept`=1.
  - `gm_mwrite` takes priority over `gm_mread` when both are high.
  - On `mwrite`&`saccept`: this cycle is beat 0. If `mlen`=0, go to WR_RESP; otherwise go to WR_DATA.
  - On `mread`&`saccept`: go to RD_DATA.
- WR_DATA:
  - `gm_saccept`=1. Each cycle with `gm_mwrite`=1 is one beat; `gm_mread` is ignored.
  - The beat count compares against the latched `mlen`. After the last beat, go to WR_RESP.
  - Each accepted beat writes the bytes whose strobe is 1. No write happens when error is set.
- WR_RESP:
  - `gm_saccept`=0.
  - Drives `svalid`=1, `slast`=1, `sid`=latched ID, `sresp`=error?010:000, `sdata`=0.
  - Holds until `mready`, then returns to IDLE.
- RD_DATA:
  - `gm_saccept`=0.
  - Issues `mlen`+1 SRAM reads into a 2-entry output skid buffer. A read issues only when the buffer will have space.
  - Each beat carries `sid` and `sresp`. `slast` is on beat `mlen`.
  - An error read returns `sdata`=0 with `sresp`=010 and still delivers all `mlen`+1 beats.
  - Leaves for IDLE in the cycle the last beat completes (`svalid`&`mready`&`slast`).
- The SRAM is inferred single-port with synchronous read. Its contents are not reset.

## Timing
- Reset: `gm_saccept`=0, `gm_svalid`=0, `gm_slast`=0, `gm_sid`=0, `gm_sresp`=0, `gm_sdata`=0, FSM=IDLE, skid buffer empty.
- `gm_saccept` rises in the first cycle after reset deassertion.
- Read latency: command accepted at cycle T gives `svalid` at T+2.
- Read throughput: with `mready` held high, beats arrive on consecutive cycles.
- Read backpressure:
  - While `mready`=0, `svalid`, `sdata`, `slast`, `sid` and `sresp` stay stable.
  - No beat is dropped or duplicated.
  - Once `mready` returns high, the beats still issue back-to-back.
- Write path:
  - A beat accepted at T is readable by a command accepted at T+1 or later.
  - The write response appears at T+1 after the last beat accepted at T.
- Next command: the earliest is the cycle after the response completes (IDLE gives `saccept`=1 in that cycle).
- Write gaps: `gm_mwrite`=0 in WR_DATA is an idle gap. The burst stays open, with no timeout.
- Reset mid-burst: all outputs return to reset values immediately. Partial writes already committed remain in the SRAM.

## Test plan
- Write then read: write INCR `mlen`=3 at 0x100, all strobes, data 0x11..11 / 0x22..22 / 0x33..33 / 0x44..44. Then read the same range. Required: OKAY write response one cycle after the last beat; 4 read beats equal to the written data; `slast` on beat 3; `sid` echoes `mid`=5.
- Byte strobes: pre-fill word 0 with 0xFFFF_FFFF_FFFF_FFFF, then write 0 with `mwstrb`=0x0F. Required: read returns 0xFFFF_FFFF_0000_0000.
- Read backpressure: 8-beat read with `mready` toggling 1,0,0,1,… Required: beats in order, values stable while stalled, exactly 8 handshakes, FSM back in IDLE after `slast`.
- Address wrap and FIXED burst:
  - INCR write of 2 beats at word 2^MEM_AW−1 lands at the last word and at word 0.
  - FIXED read `mlen`=2 returns the same word three times.
- Errors and priority:
  - `msize`=2 write returns `sresp`=010 and the SRAM is unchanged.
  - With `mread` and `mwrite` high together in IDLE, the write is serviced first.
- Reset mid-read: assert `axi_rst` on beat 2 of a 4-beat read. Required: `svalid`=0 immediately; `saccept`=1 one cycle after release; a new read returns correct data.
